// File: rtl/ms_countdown_timer_if.sv
// Control and status bundle between the game controller and the round timer.
// The master drives load/start/pause and the ms tick; the slave is the timer.
interface ms_countdown_timer_if;
   logic       ms_Tick;
   logic       load;
   logic [3:0] load_Tens;
   logic [3:0] load_Ones;
   logic       start;
   logic       pause;
   logic       timer_Enable;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       running;
   logic       expired;
   logic       done;

   modport master (
      output ms_Tick, load, load_Tens, load_Ones, start, pause,
      input  timer_Enable, tens, ones, running, expired, done
   );

   modport slave (
      input  ms_Tick, load, load_Tens, load_Ones, start, pause,
      output timer_Enable, tens, ones, running, expired, done
   );
endinterface

// File: rtl/ms_countdown_timer.sv
// Two-digit BCD round timer (00-99 s) that accumulates 1 ms ticks into seconds.
// Offers load/start/pause control and a one-cycle expiry pulse for the game controller.
module ms_countdown_timer #(
   parameter int MS_PER_SEC = 1000,
   parameter int MS_WIDTH   = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   ms_countdown_timer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam logic [MS_WIDTH-1:0] MS_LAST = MS_WIDTH'(MS_PER_SEC - 1);

   state_t              state_reg, state_next;
   logic [MS_WIDTH-1:0] ms_count_reg, ms_count_next;
   logic [3:0]          tens_reg, tens_next;
   logic [3:0]          ones_reg, ones_next;
   logic                expired_reg, expired_next;

   logic [3:0] load_digit  [2];
   logic [3:0] clamp_digit [2];
   logic       pause_hit;
   logic       start_hit;
   logic       tick_hit;

   // Index 0 is the ones digit, index 1 the tens digit; non-BCD input saturates at 9.
   assign load_digit[0] = bus.load_Ones;
   assign load_digit[1] = bus.load_Tens;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_clamp
         assign clamp_digit[gi] = (load_digit[gi] > 4'd9) ? 4'd9 : load_digit[gi];
      end
   endgenerate

   assign pause_hit = bus.pause && (state_reg == RUN);
   assign start_hit = bus.start && ((state_reg == IDLE) || (state_reg == PAUSE));
   assign tick_hit  = bus.ms_Tick && (state_reg == RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         ms_count_reg <= '0;
         tens_reg     <= 4'd0;
         ones_reg     <= 4'd0;
         expired_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ms_count_reg <= ms_count_next;
         tens_reg     <= tens_next;
         ones_reg     <= ones_next;
         expired_reg  <= expired_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ms_count_next = ms_count_reg;
      tens_next     = tens_reg;
      ones_next     = ones_reg;

      if (bus.load) begin
         tens_next     = clamp_digit[1];
         ones_next     = clamp_digit[0];
         ms_count_next = '0;
         state_next    = IDLE;
      end else if (pause_hit) begin
         state_next = PAUSE;
      end else if (start_hit) begin
         state_next = ((tens_reg == 4'd0) && (ones_reg == 4'd0)) ? EXPIRED : RUN;
      end else if (tick_hit) begin
         if (ms_count_reg == MS_LAST) begin
            ms_count_next = '0;
            if (ones_reg != 4'd0) begin
               ones_next = ones_reg - 4'd1;
            end else if (tens_reg != 4'd0) begin
               ones_next = 4'd9;
               tens_next = tens_reg - 4'd1;
            end
            // Reaching 00 ends the round on this same edge.
            if ((tens_reg == 4'd0) && (ones_reg <= 4'd1)) begin
               state_next = EXPIRED;
            end
         end else begin
            ms_count_next = ms_count_reg + 1'b1;
         end
      end

      expired_next = (state_next == EXPIRED) && (state_reg != EXPIRED);
   end

   assign bus.timer_Enable = (state_reg == RUN);
   assign bus.running      = (state_reg == RUN);
   assign bus.done         = (state_reg == EXPIRED);
   assign bus.expired      = expired_reg;
   assign bus.tens         = tens_reg;
   assign bus.ones         = ones_reg;

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Bench for the round timer: a seconds-level model checked every cycle plus
// directed scenarios with hand-computed digit and flag expectations.
module tb_ms_countdown_timer;

   localparam int MSPS = 4;

   logic clock;
   logic reset;
   int   n_pass;
   int   n_total;

   ms_countdown_timer_if timer_bus ();

   ms_countdown_timer #(
      .MS_PER_SEC (MSPS),
      .MS_WIDTH   (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (timer_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: remaining time kept as a plain integer number of seconds.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
   int m_state;
   int m_secs;
   int m_ms;
   int m_pulse;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_state <= M_IDLE;
         m_secs  <= 0;
         m_ms    <= 0;
         m_pulse <= 0;
      end else begin
         m_pulse <= 0;
         if (timer_bus.load) begin
            m_secs  <= ((timer_bus.load_Tens > 9) ? 9 : int'(timer_bus.load_Tens)) * 10
                     + ((timer_bus.load_Ones > 9) ? 9 : int'(timer_bus.load_Ones));
            m_ms    <= 0;
            m_state <= M_IDLE;
         end else if (timer_bus.pause && m_state == M_RUN) begin
            m_state <= M_PAUSE;
         end else if (timer_bus.start && (m_state == M_IDLE || m_state == M_PAUSE)) begin
            if (m_secs == 0) begin
               m_state <= M_EXP;
               m_pulse <= 1;
            end else begin
               m_state <= M_RUN;
            end
         end else if (timer_bus.ms_Tick && m_state == M_RUN) begin
            if (m_ms == MSPS - 1) begin
               m_ms   <= 0;
               m_secs <= m_secs - 1;
               if (m_secs == 1) begin
                  m_state <= M_EXP;
                  m_pulse <= 1;
               end
            end else begin
               m_ms <= m_ms + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         check("model_tens",    32'(timer_bus.tens),         32'(m_secs / 10));
         check("model_ones",    32'(timer_bus.ones),         32'(m_secs % 10));
         check("model_enable",  32'(timer_bus.timer_Enable), 32'(m_state == M_RUN));
         check("model_running", 32'(timer_bus.running),      32'(m_state == M_RUN));
         check("model_done",    32'(timer_bus.done),         32'(m_state == M_EXP));
         check("model_expired", 32'(timer_bus.expired),      32'(m_pulse));
      end
   end

   // Apply inputs for one clock edge; returns just after the edge.
   task automatic drive(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                        input logic st, input logic pa, input logic tk);
      timer_bus.load      = ld;
      timer_bus.load_Tens = lt;
      timer_bus.load_Ones = lo;
      timer_bus.start     = st;
      timer_bus.pause     = pa;
      timer_bus.ms_Tick   = tk;
      @(posedge clock);
      #2;
      timer_bus.load    = 1'b0;
      timer_bus.start   = 1'b0;
      timer_bus.pause   = 1'b0;
      timer_bus.ms_Tick = 1'b0;
      $display("txn ld=%0b lt=%0d lo=%0d st=%0b pa=%0b tk=%0b -> %0d%0d run=%0b done=%0b exp=%0b",
               ld, lt, lo, st, pa, tk, timer_bus.tens, timer_bus.ones,
               timer_bus.running, timer_bus.done, timer_bus.expired);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic load_val(input logic [3:0] t, input logic [3:0] o);
      drive(1'b1, t, o, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle_cycle();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      timer_bus.load      = 1'b0;
      timer_bus.load_Tens = 4'd0;
      timer_bus.load_Ones = 4'd0;
      timer_bus.start     = 1'b0;
      timer_bus.pause     = 1'b0;
      timer_bus.ms_Tick   = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;

      check("rst_tens", 32'(timer_bus.tens), 0);
      check("rst_enable", 32'(timer_bus.timer_Enable), 0);
      check("rst_done", 32'(timer_bus.done), 0);

      // Basic countdown from 02
      load_val(4'd0, 4'd2);
      check("basic_load_ones", 32'(timer_bus.ones), 2);
      do_start();
      check("basic_enable_rise", 32'(timer_bus.timer_Enable), 1);
      ticks(MSPS);
      check("basic_01", 32'(timer_bus.ones), 1);
      ticks(MSPS - 1);
      check("basic_still_01", 32'(timer_bus.ones), 1);
      ticks(1);
      check("basic_00", 32'(timer_bus.ones), 0);
      check("basic_expired", 32'(timer_bus.expired), 1);
      check("basic_done", 32'(timer_bus.done), 1);
      check("basic_enable_fall", 32'(timer_bus.timer_Enable), 0);
      idle_cycle();
      check("basic_expired_one_cycle", 32'(timer_bus.expired), 0);
      check("basic_done_held", 32'(timer_bus.done), 1);

      // Borrow and clamp
      load_val(4'd1, 4'd0);
      do_start();
      ticks(MSPS);
      check("borrow_tens", 32'(timer_bus.tens), 0);
      check("borrow_ones", 32'(timer_bus.ones), 9);
      load_val(4'd1, 4'hF);
      check("clamp_tens", 32'(timer_bus.tens), 1);
      check("clamp_ones", 32'(timer_bus.ones), 9);
      load_val(4'hC, 4'd3);
      check("clamp_tens_hi", 32'(timer_bus.tens), 9);

      // Pause / resume keeps partial milliseconds
      load_val(4'd0, 4'd5);
      do_start();
      ticks(2);
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      check("pause_running", 32'(timer_bus.running), 0);
      ticks(10);
      check("pause_hold", 32'(timer_bus.ones), 5);
      do_start();
      ticks(1);
      check("resume_not_yet", 32'(timer_bus.ones), 5);
      ticks(1);
      check("resume_04", 32'(timer_bus.ones), 4);

      // Zero start and EXPIRED hold
      load_val(4'd0, 4'd0);
      do_start();
      check("zero_expired", 32'(timer_bus.expired), 1);
      check("zero_done", 32'(timer_bus.done), 1);
      ticks(6);
      do_start();
      check("hold_ones", 32'(timer_bus.ones), 0);
      check("hold_expired_low", 32'(timer_bus.expired), 0);
      check("hold_done", 32'(timer_bus.done), 1);
      load_val(4'd0, 4'd3);
      check("reload_done", 32'(timer_bus.done), 0);
      check("reload_ones", 32'(timer_bus.ones), 3);

      // Load together with the final tick
      load_val(4'd0, 4'd1);
      do_start();
      ticks(MSPS - 1);
      drive(1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1);
      check("sim_load_ones", 32'(timer_bus.ones), 7);
      check("sim_load_expired", 32'(timer_bus.expired), 0);
      check("sim_load_running", 32'(timer_bus.running), 0);
      idle_cycle();
      check("sim_load_done", 32'(timer_bus.done), 0);

      // Pause together with the final tick
      load_val(4'd0, 4'd1);
      do_start();
      ticks(MSPS - 1);
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("sim_pause_ones", 32'(timer_bus.ones), 1);
      check("sim_pause_expired", 32'(timer_bus.expired), 0);
      check("sim_pause_running", 32'(timer_bus.running), 0);
      do_start();
      ticks(1);
      check("sim_pause_resume_expired", 32'(timer_bus.expired), 1);

      // Asynchronous reset in the middle of a run
      load_val(4'd0, 4'd9);
      do_start();
      ticks(2);
      #1;
      reset = 1'b1;
      #1;
      check("arst_ones", 32'(timer_bus.ones), 0);
      check("arst_enable", 32'(timer_bus.timer_Enable), 0);
      check("arst_running", 32'(timer_bus.running), 0);
      check("arst_done", 32'(timer_bus.done), 0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      idle_cycle();
      check("arst_tens", 32'(timer_bus.tens), 0);

      repeat (2) @(posedge clock);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ms_countdown_timer.md
# ms_countdown_timer

Downstream consumer of the 1 ms tick generator: counts 1 ms pulses into seconds and runs a two-digit BCD countdown (00–99 s) for the game round timer. It gates the upstream tick generator through its enable, exposes the remaining time as BCD digits for the seven-segment display path, and flags round expiry to the game controller. It provides start, pause and load control with a small state machine.

## Interface
- MS_PER_SEC, 1000, ticks per second; overridden small in simulation, minimum 2.
- MS_WIDTH, 10, counter width; must satisfy 2^MS_WIDTH ≥ MS_PER_SEC.

- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- ms_Tick  in  1  one-cycle pulse every 1 ms from the upstream tick generator
- load  in  1  load the BCD start value and return to IDLE
- load_Tens  in  4  BCD tens digit to load
- load_Ones  in  4  BCD ones digit to load
- start  in  1  begin or resume the countdown
- pause  in  1  hold the countdown
- timer_Enable  out  1  drives the upstream tick generator enable; high only in RUN
- tens  out  4  remaining seconds, BCD tens
- ones  out  4  remaining seconds, BCD ones
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse on entry to EXPIRED
- done  out  1  level, high in EXPIRED

## Operation
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSE: holding the count.
  - EXPIRED: count reached 00.
- Control priority each cycle: load > pause > start > ms_Tick.
- load, from any state:
  - Digits are registered, with any digit > 9 clamped to 9.
  - ms_count clears to 0 and the state goes to IDLE.
- start:
  - From IDLE or PAUSE: goes to RUN.
  - If start is seen with tens=ones=0 in IDLE or PAUSE: go to EXPIRED instead and pulse expired.
  - Ignored in RUN and EXPIRED.
- pause:
  - From RUN: goes to PAUSE. ms_count is preserved.
  - Ignored in all other states.
- ms_Tick in RUN:
  - If ms_count = MS_PER_SEC−1: ms_count becomes 0 and the BCD value decrements.
  - Otherwise ms_count increments.
- ms_Tick outside RUN is ignored.
- BCD decrement:
  - ones ≠ 0: ones−1.
  - ones = 0: ones becomes 9 and tens becomes tens−1.
- When a decrement produces 00, the state goes to EXPIRED on the same edge and expired pulses.
- No wrap below 00.
- EXPIRED holds 00 until load.
- Upstream interaction: the upstream generator restarts its period whenever its enable drops. Each pause therefore discards up to 1 ms of partial period; this error is accepted.

## Timing
- Reset values:
  - state IDLE, ms_count 0.
  - tens 0, ones 0.
  - timer_Enable 0, running 0, expired 0, done 0.
- All outputs are registered or decoded directly from registered state; no input-to-output combinational path.
- load, start and pause take effect on the edge where they are sampled high; the new state is visible the next cycle.
- timer_Enable:
  - Rises the cycle after start is sampled.
  - Falls the cycle after pause, load or expiry.
- Digit update: tens/ones change on the edge that samples the MS_PER_SEC-th tick.
- expired is high for exactly one cycle, coincident with the first cycle done is high.
- Simultaneous events:
  - load with a final tick: load wins; no expired pulse.
  - pause with a final tick: pause wins; the tick is dropped and the count stays at 01 with ms_count unchanged.
- Reset mid-operation: all registers go to reset values immediately (asynchronous). Deassertion is synchronous to clock at the integration level.
- Full round at defaults: load 99, then 99 × 1000 ticks until expired.

## Test plan
- **Reset:** assert reset mid-RUN -> all outputs 0 immediately, state IDLE, timer_Enable 0.
- **Basic countdown** (MS_PER_SEC=4): load 02, start, 4 ticks -> 01; 4 more ticks -> 00, expired pulse 1 cycle, done=1, timer_Enable=0.
- **Borrow:** load 10, start, 4 ticks -> tens=0, ones=9. Load 1F -> clamps to tens=1, ones=9.
- **Pause/resume:** load 05, start, 2 ticks, pause, 10 ticks -> remains 05, ms_count=2. start, 2 ticks -> 04.
- **Zero start and EXPIRED hold:** load 00, start -> EXPIRED next cycle with expired pulse. Further ticks/start -> no change. load 03 -> IDLE, done=0.
- **Simultaneous:**
  - At 01 with ms_count=3, load 07 with a tick -> 07, IDLE, no expired.
  - Repeat with pause plus tick -> PAUSE, 01, no expired.
